// File: rtl/mux_rr_stream_if.sv
// Stream bundle for mux_rr_stream: NCH producer channels in, one consumer out.
// With MUX_PKT_LOCK_EN defined the bundle also carries the packet-end markers
// in_last/out_last.
interface mux_rr_stream_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = 2
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_chan;
  logic                 out_valid;
  logic                 out_ready;
`ifdef MUX_PKT_LOCK_EN
  logic [NCH-1:0]       in_last;
  logic                 out_last;

  // Multiplexer side.
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_chan, out_valid, out_last
  );

  // Producer/consumer side.
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_chan, out_valid, out_last
  );
`else
  // Multiplexer side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  // Producer/consumer side.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
`endif
endinterface

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-channel streaming multiplexer with a one-entry registered
// output stage. mode=0 takes the channel named by sel; mode=1 arbitrates
// round-robin starting from the channel after the last one served.
// Optional macro MUX_PKT_LOCK_EN: holds the grant on one channel from the
// first beat of a packet through its in_last beat, and registers out_last.
module mux_rr_stream #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  mux_rr_stream_if.slave  bus
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  logic [SELW-1:0]  ptr;
  logic             load_ok;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;
  logic             beat_last;
  logic [NCH-1:0]   ready;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  chan_q;
  logic             valid_q;
`ifdef MUX_PKT_LOCK_EN
  logic             lock_active;
  logic [SELW-1:0]  lock_chan;
  logic             last_q;
`endif

  // Channel index base+off folded back into 0..NCH-1.
  function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCH) s -= NCH;
    return SELW'(s);
  endfunction

  // The output register can take a word when empty or being emptied this cycle.
  assign load_ok = !valid_q | bus.out_ready;

  // Grant: fixed select or round-robin search from ptr; a held packet overrides both.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      for (int k = 0; k < NCH; k++) begin
        if (sel == SELW'(k) && bus.in_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(k);
        end
      end
    end else begin
      // Walk from the farthest candidate to the nearest so the nearest valid one wins.
      for (int i = NCH - 1; i >= 0; i--) begin
        if (bus.in_valid[wrap_idx(ptr, i)]) begin
          grant_vld = 1'b1;
          grant_idx = wrap_idx(ptr, i);
        end
      end
    end
`ifdef MUX_PKT_LOCK_EN
    if (lock_active) begin
      grant_vld = bus.in_valid[lock_chan];
      grant_idx = lock_chan;
    end
`endif
  end

  assign grant_data = bus.in_data[grant_idx*WIDTH +: WIDTH];
  assign xfer       = grant_vld & load_ok;

`ifdef MUX_PKT_LOCK_EN
  assign beat_last = bus.in_last[grant_idx];
`else
  assign beat_last = 1'b1;
`endif

  // Ready is one-hot on the granted channel, and forced off while reset is high.
  always_comb begin
    ready = '0;
    if (xfer && !reset) ready[grant_idx] = 1'b1;
  end

  assign bus.in_ready = ready;

  // Output stage: load on a transfer, drop valid once the consumer takes it, else hold.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else if (xfer) begin
      data_q  <= grant_data;
      chan_q  <= grant_idx;
      valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;

  // Round-robin pointer moves past the served channel, only at a packet end in mode 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer && mode && beat_last) begin
      ptr <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef MUX_PKT_LOCK_EN
  // Packet lock: a non-last beat pins the grant to its channel until the last beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_chan   <= '0;
      last_q      <= 1'b0;
    end else if (xfer) begin
      lock_active <= !beat_last;
      lock_chan   <= grant_idx;
      last_q      <= beat_last;
    end
  end

  assign bus.out_last = last_q;
`endif

endmodule

// File: tb/tb_mux_rr_stream.sv
// Self-checking bench for mux_rr_stream (NCH=4, WIDTH=8). A cycle-level
// reference model tracks the output word, round-robin pointer and packet lock;
// directed scenarios add explicit expectations on top of it.
module tb_mux_rr_stream;

  localparam int NCH   = 4;
  localparam int WIDTH = 8;
  localparam int SELW  = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [NCH-1:0]  tb_last;

  mux_rr_stream_if #(.NCH(NCH), .WIDTH(WIDTH), .SELW(SELW)) bus ();

  mux_rr_stream #(.NCH(NCH), .WIDTH(WIDTH), .SELW(SELW)) dut (
    .clock (clock),
    .reset (reset),
    .mode  (mode),
    .sel   (sel),
    .bus   (bus)
  );

`ifdef MUX_PKT_LOCK_EN
  assign bus.in_last = tb_last;
`endif

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  bit m_valid;
  int m_data;
  int m_chan;
  int m_ptr;
  bit m_lock;
  int m_lock_ch;
  bit m_last;

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
    m_lock = 0; m_lock_ch = 0; m_last = 0;
  endtask

  function automatic bit beat_is_last(input int g);
`ifdef MUX_PKT_LOCK_EN
    return tb_last[g];
`else
    return 1'b1;
`endif
  endfunction

  // Channel the rules say should be granted now, or -1 for none.
  function automatic int ref_grant();
    if (m_lock) return bus.in_valid[m_lock_ch] ? m_lock_ch : -1;
    if (!mode) return (int'(sel) < NCH && bus.in_valid[sel]) ? int'(sel) : -1;
    for (int i = 0; i < NCH; i++) begin
      if (bus.in_valid[(m_ptr + i) % NCH]) return (m_ptr + i) % NCH;
    end
    return -1;
  endfunction

  // One clock: inputs are already driven (from a negedge). Checks in_ready,
  // advances the model at posedge, checks the registered outputs at negedge.
  task automatic cycle(input string tag);
    int g;
    bit ld;
    logic [NCH-1:0] exp_rdy;
    #1;
    ld = !m_valid || bus.out_ready;
    g = ref_grant();
    exp_rdy = '0;
    if (ld && g >= 0) exp_rdy[g] = 1'b1;
    n_vec++;
    if (bus.in_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL %s in_ready: got %b expected %b", tag, bus.in_ready, exp_rdy);
    end
    @(posedge clock);
    if (exp_rdy != '0) begin
      m_valid = 1;
      m_data  = int'(bus.in_data[g*WIDTH +: WIDTH]);
      m_chan  = g;
      m_last  = beat_is_last(g);
      if (!m_last) begin
        m_lock = 1; m_lock_ch = g;
      end else begin
        m_lock = 0;
        if (mode) m_ptr = (g + 1) % NCH;
      end
    end else if (m_valid && bus.out_ready) begin
      m_valid = 0;
    end
    @(negedge clock);
    n_vec++;
    if (bus.out_valid !== m_valid) begin
      n_err++;
      $display("FAIL %s out_valid: got %b expected %b", tag, bus.out_valid, m_valid);
    end
    if (m_valid) begin
      n_vec++;
      if (bus.out_data !== WIDTH'(m_data) || bus.out_chan !== SELW'(m_chan)) begin
        n_err++;
        $display("FAIL %s out_data/out_chan: got %h/%0d expected %h/%0d",
                 tag, bus.out_data, bus.out_chan, m_data, m_chan);
      end
`ifdef MUX_PKT_LOCK_EN
      n_vec++;
      if (bus.out_last !== m_last) begin
        n_err++;
        $display("FAIL %s out_last: got %b expected %b", tag, bus.out_last, m_last);
      end
`endif
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mode = 1'b1; sel = '0; tb_last = '1;
    bus.in_data = 32'h44332211; bus.in_valid = '1; bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_chan !== '0 || bus.in_ready !== '0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b d=%h c=%0d rdy=%b expected all zero",
               bus.out_valid, bus.out_data, bus.out_chan, bus.in_ready);
    end
    bus.in_valid = '0;
    reset = 1'b0;
    cycle("reset_idle");
  endtask

  task automatic test_fixed();
    mode = 1'b0; bus.in_data = 32'h44332211; bus.in_valid = '1; bus.out_ready = 1'b1;
    for (int s = 0; s < NCH; s++) begin
      sel = SELW'(s);
      cycle("fixed_sel");
      n_vec++;
      if (bus.out_chan !== SELW'(s) || bus.out_data !== WIDTH'(8'h11 * (s + 1))) begin
        n_err++;
        $display("FAIL fixed_sel%0d: got %h/%0d expected %h/%0d",
                 s, bus.out_data, bus.out_chan, 8'h11 * (s + 1), s);
      end
    end
    sel = 2'd3; bus.in_valid = 4'b0111;
    cycle("fixed_invalid");
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fixed_invalid out_valid: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_rr_fairness();
    mode = 1'b1; bus.in_valid = '1; bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle("rr_fair");
      n_vec++;
      if (bus.out_chan !== SELW'(i % NCH)) begin
        n_err++;
        $display("FAIL rr_fair step %0d out_chan: got %0d expected %0d", i, bus.out_chan, i % NCH);
      end
    end
  endtask

  task automatic test_rr_skip();
    int exp_seq[4] = '{1, 3, 1, 3};
    mode = 1'b1; bus.out_ready = 1'b1;
    bus.in_valid = 4'b0001;
    cycle("rr_skip_prime");
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle("rr_skip");
      n_vec++;
      if (bus.out_chan !== SELW'(exp_seq[i])) begin
        n_err++;
        $display("FAIL rr_skip step %0d out_chan: got %0d expected %0d", i, bus.out_chan, exp_seq[i]);
      end
    end
    bus.in_valid = '1;
    cycle("rr_wrap");
    n_vec++;
    if (bus.out_chan !== 2'd0) begin
      n_err++;
      $display("FAIL rr_wrap out_chan: got %0d expected 0", bus.out_chan);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held_data;
    logic [SELW-1:0]  held_chan;
    mode = 1'b1; bus.in_valid = '1; bus.out_ready = 1'b1;
    bus.in_data = {$urandom, $urandom} % (64'd1 << (NCH*WIDTH));
    cycle("bp_load");
    held_data = bus.out_data;
    held_chan = bus.out_chan;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_stall");
      n_vec++;
      if (bus.out_data !== held_data || bus.out_valid !== 1'b1 || bus.in_ready !== '0) begin
        n_err++;
        $display("FAIL bp_stall %0d: got d=%h v=%b rdy=%b expected d=%h v=1 rdy=0",
                 i, bus.out_data, bus.out_valid, bus.in_ready, held_data);
      end
    end
    bus.out_ready = 1'b1;
    cycle("bp_release");
    n_vec++;
    if (bus.out_chan !== SELW'((int'(held_chan) + 1) % NCH)) begin
      n_err++;
      $display("FAIL bp_release out_chan: got %0d expected %0d",
               bus.out_chan, (int'(held_chan) + 1) % NCH);
    end
  endtask

`ifdef MUX_PKT_LOCK_EN
  task automatic test_lock();
    mode = 1'b0; sel = 2'd2; bus.out_ready = 1'b1;
    bus.in_valid = 4'b0101; bus.in_data = 32'h00CC00AA;
    for (int b = 0; b < 4; b++) begin
      tb_last = (b == 2) ? 4'b1111 : 4'b1011;
      cycle("lock");
      if (b == 0) mode = 1'b1;
      n_vec++;
      if (bus.out_chan !== ((b < 3) ? 2'd2 : 2'd0) || bus.out_last !== (b >= 2)) begin
        n_err++;
        $display("FAIL lock beat %0d: got chan=%0d last=%b expected chan=%0d last=%b",
                 b, bus.out_chan, bus.out_last, (b < 3) ? 2 : 0, b >= 2);
      end
    end
    tb_last = '1;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 7 == 0) mode = 1'($urandom);
      sel           = SELW'($urandom);
      bus.in_valid  = NCH'($urandom);
      bus.in_data   = (NCH*WIDTH)'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tb_last       = NCH'($urandom);
      cycle("random");
    end
    tb_last = '1;
  endtask

  task automatic test_reset_midstream();
    mode = 1'b1; bus.in_valid = '1; bus.out_ready = 1'b1; bus.in_data = 32'h44332211;
    repeat (2) cycle("mid_pre");
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.in_ready !== '0) begin
      n_err++;
      $display("FAIL mid_reset async: got v=%b d=%h rdy=%b expected 0/00/0000",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    cycle("mid_post");
    n_vec++;
    if (bus.out_chan !== 2'd0 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_post first grant: got chan=%0d v=%b expected 0/1", bus.out_chan, bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_fairness();
    test_rr_skip();
    test_backpressure();
`ifdef MUX_PKT_LOCK_EN
    test_lock();
`endif
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- Parametrised N-channel, WIDTH-bit streaming multiplexer. Successor to the team's combinational 4-to-1 mux.
- Adds per-channel valid/ready handshakes, a registered output stage, and two selection modes:
  - fixed select, driven by the `sel` port;
  - fair round-robin arbitration.
- Sits between several producer streams and a single consumer, e.g. a stimulus source feeding a shared bus or a display/trace path.

Parameters:
- NCH, 4, number of input channels (2..16).
- WIDTH, 8, data bits per channel.
- SELW, 2, select/channel-index width; must satisfy 2**SELW >= NCH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel chosen in fixed mode; values >= NCH select no channel.
- in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; one-hot or zero.
- out_data  output  WIDTH  registered data.
- out_chan  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_data=0, out_chan=0, round-robin pointer=0.
  - in_ready=0 while reset is high.
- Output register is one entry. load_ok = !out_valid | out_ready (combinational).
- Grant (combinational):
  - Fixed mode: grant = channel sel if sel<NCH and in_valid[sel], else none.
  - Round-robin mode: grant = first k with in_valid[k], searching ptr, ptr+1, ... NCH-1, 0, ... ptr-1, with wrap-around mod NCH.
- in_ready[k] = load_ok & (grant==k). Exactly one or zero channels are ready per cycle.
- A transfer occurs when in_valid[k] & in_ready[k]. On that clock edge:
  - out_data <= channel k data;
  - out_chan <= k;
  - out_valid <= 1.
- Latency: an accepted word appears on out_* on the cycle after acceptance.
- Throughput: 1 word/cycle when out_ready is held high.
- If out_valid & out_ready and there is no transfer, out_valid <= 0 and out_data/out_chan hold their values.
- Stall: while out_valid & !out_ready, out_data/out_chan/out_valid hold and all in_ready are 0.
- Round-robin pointer:
  - On a transfer in round-robin mode: ptr <= (k==NCH-1) ? 0 : k+1.
  - No transfer: the pointer holds.
  - Fixed mode: the pointer is not updated.
- Mode or sel changes take effect on the next cycle's grant. They never corrupt a word already in the output register.
- No input valid: grant none, in_ready all 0. out_valid drains normally.

Optional Feature:
- Macro: MUX_PKT_LOCK_EN.
- When defined:
  - Adds port in_last (input, NCH) and port out_last (output, 1; registered with data, reset 0).
  - After a transfer with in_last[k]=0, grant is locked to channel k in both modes, ignoring sel and ptr, until a transfer with in_last[k]=1.
  - The round-robin pointer advances only on that last beat.
  - Reset clears the lock.
- When undefined: no lock; every beat is arbitrated independently; the in_last/out_last ports do not exist.

Test Plan:
- Reset mid-stream: assert reset with out_valid=1 -> out_valid, out_data, in_ready go 0 immediately, without waiting for a clock edge. After release, the first round-robin grant goes to channel 0.
- Fixed mode (NCH=4, WIDTH=8):
  - in_data = {0x44,0x33,0x22,0x11}, all valid, out_ready=1.
  - Step sel through 0,1,2,3 -> out_data 0x11, 0x22, 0x33, 0x44 one cycle later, with out_chan 0..3.
  - sel=3 with in_valid[3]=0 -> no transfer.
- Round-robin fairness: all 4 channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 with in_ready one-hot each cycle.
- Round-robin wrap/skip: only channels 1 and 3 valid -> out_chan 1,3,1,3. The pointer after channel 3 wraps to 0.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 -> out_data stable and in_ready=0. Release -> the next word arrives 1 cycle later, and no word is lost or duplicated.
- MUX_PKT_LOCK_EN:
  - Channel 2 sends 3 beats (last on beat 3) while channel 0 is valid -> out_chan 2,2,2, then 0.
  - out_last=1 only on the third beat.
